// File: rtl/seg_scan_decoder_if.sv
// Bus bundle for the seven-segment scan snooper: the scan-bus inputs and the
// decoded-frame stream with its valid/ready handshake.
interface seg_scan_decoder_if;
    logic [7:0]  seg_in;
    logic [7:0]  dig_sel;
    logic        frame_ready;
    logic [31:0] frame_digits;
    logic [7:0]  frame_dp;
    logic        frame_err;
    logic        frame_valid;
    logic        overrun;

    modport master (
        output seg_in,
        output dig_sel,
        output frame_ready,
        input  frame_digits,
        input  frame_dp,
        input  frame_err,
        input  frame_valid,
        input  overrun
    );

    modport slave (
        input  seg_in,
        input  dig_sel,
        input  frame_ready,
        output frame_digits,
        output frame_dp,
        output frame_err,
        output frame_valid,
        output overrun
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 8-digit seven-segment bus, commits each digit once it has
// been stable long enough, and streams complete decoded frames over valid/ready.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_decoder_if.slave bus
);

    typedef enum logic {
        TRACK = 1'b0,
        HELD  = 1'b1
    } state_t;

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    function automatic logic [3:0] decode_seg(input logic [7:0] seg);
        logic [3:0] code;
        case ({seg[7:1], 1'b0})
            8'hFC:   code = 4'h0;
            8'h60:   code = 4'h1;
            8'hDA:   code = 4'h2;
            8'hF2:   code = 4'h3;
            8'h66:   code = 4'h4;
            8'hB6:   code = 4'h5;
            8'hBE:   code = 4'h6;
            8'hE0:   code = 4'h7;
            8'hFE:   code = 4'h8;
            8'hE6:   code = 4'h9;
            8'h02:   code = 4'ha;
            8'h00:   code = 4'hb;
            default: code = 4'hf;
        endcase
        return code;
    endfunction

    function automatic logic is_onehot(input logic [7:0] s);
        return (s != 8'h00) && ((s & (s - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [2:0] sel_index(input logic [7:0] s);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic has_invalid(input logic [31:0] digits);
        logic err;
        err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (digits[4*i +: 4] == 4'hf) begin
                err = 1'b1;
            end else begin
                err = err;
            end
        end
        return err;
    endfunction

    logic [7:0]  seg_q, sel_q;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  dp_q, dp_d;
    logic [7:0]  seen_q, seen_d;
    logic        pend_q, pend_d;
    logic [31:0] frame_digits_q, frame_digits_d;
    logic [7:0]  frame_dp_q, frame_dp_d;
    logic        frame_err_q, frame_err_d;
    logic        frame_valid_q, frame_valid_d;
    logic        overrun_q, overrun_d;

    logic        same_s, legal_s, commit_s, complete_s, out_free_s;
    logic [7:0]  cnt_inc_s, seen_set_s;
    logic [2:0]  idx_s;

    // Stability is judged on the sample about to enter the input register versus
    // the one already held, so the count reaches S on the S-th edge of a run.
    assign same_s     = ({bus.seg_in, bus.dig_sel} == {seg_q, sel_q});
    assign legal_s    = is_onehot(bus.dig_sel);
    assign cnt_inc_s  = cnt_q + 8'd1;
    assign idx_s      = sel_index(sel_q);
    assign seen_set_s = seen_q | (8'h01 << idx_s);
    assign complete_s = commit_s && (seen_set_s == 8'hFF);
    assign out_free_s = !frame_valid_q || bus.frame_ready;

    // Input sampling stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= 8'h00;
            sel_q <= 8'h00;
        end else begin
            seg_q <= bus.seg_in;
            sel_q <= bus.dig_sel;
        end
    end

    // Capture FSM state and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TRACK;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TRACK: begin
                if (legal_s && same_s && (cnt_inc_s == STABLE_C)) begin
                    state_d = HELD;
                end else begin
                    state_d = TRACK;
                end
            end
            HELD: begin
                if (!legal_s || !same_s) begin
                    state_d = TRACK;
                end else begin
                    state_d = HELD;
                end
            end
            default: state_d = TRACK;
        endcase
    end

    // Capture FSM outputs: counter update and commit strobe.
    always_comb begin
        cnt_d    = cnt_q;
        commit_s = 1'b0;
        case (state_q)
            TRACK: begin
                if (!legal_s) begin
                    cnt_d = 8'd0;
                end else if (same_s) begin
                    cnt_d    = cnt_inc_s;
                    commit_s = (cnt_inc_s == STABLE_C);
                end else begin
                    cnt_d = 8'd1;
                end
            end
            HELD: begin
                if (!legal_s) begin
                    cnt_d = 8'd0;
                end else if (!same_s) begin
                    cnt_d = 8'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d    = 8'd0;
                commit_s = 1'b0;
            end
        endcase
    end

    // Slot assembly and offer of completed frames to the output stage.
    always_comb begin
        digits_d       = digits_q;
        dp_d           = dp_q;
        seen_d         = seen_q;
        pend_d         = complete_s;
        frame_digits_d = frame_digits_q;
        frame_dp_d     = frame_dp_q;
        frame_err_d    = frame_err_q;
        frame_valid_d  = frame_valid_q;
        overrun_d      = overrun_q;
        if (commit_s) begin
            digits_d[{idx_s, 2'b00} +: 4] = decode_seg(seg_q);
            dp_d[idx_s]                   = seg_q[0];
            seen_d                        = complete_s ? 8'h00 : seen_set_s;
        end else begin
            seen_d = seen_q;
        end
        if (pend_q && out_free_s) begin
            frame_digits_d = digits_q;
            frame_dp_d     = dp_q;
            frame_err_d    = has_invalid(digits_q);
            frame_valid_d  = 1'b1;
        end else if (pend_q) begin
            overrun_d = 1'b1;
        end else begin
            frame_valid_d = frame_valid_q && !bus.frame_ready;
        end
    end

    // Slot and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q       <= 32'hbbbb_bbbb;
            dp_q           <= 8'h00;
            seen_q         <= 8'h00;
            pend_q         <= 1'b0;
            frame_digits_q <= 32'h0000_0000;
            frame_dp_q     <= 8'h00;
            frame_err_q    <= 1'b0;
            frame_valid_q  <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            digits_q       <= digits_d;
            dp_q           <= dp_d;
            seen_q         <= seen_d;
            pend_q         <= pend_d;
            frame_digits_q <= frame_digits_d;
            frame_dp_q     <= frame_dp_d;
            frame_err_q    <= frame_err_d;
            frame_valid_q  <= frame_valid_d;
            overrun_q      <= overrun_d;
        end
    end

    assign bus.frame_digits = frame_digits_q;
    assign bus.frame_dp     = frame_dp_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.frame_valid  = frame_valid_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans hand-built digit patterns and checks
// the decoded frames, handshake, overrun and reset behaviour.
module tb_seg_scan_decoder;

    localparam logic [63:0] CLEAN   = 64'hFE_DA_60_FC_E6_00_02_F2;
    localparam logic [63:0] INVAL   = 64'hFE_DA_81_FC_E6_00_02_F2;
    localparam logic [63:0] COUNT   = 64'hE0_BE_B6_66_F2_DA_60_FC;
    localparam logic [63:0] EIGHTS  = 64'hFE_FE_FE_FE_FE_FE_FE_FE;
    localparam logic [63:0] NINES   = 64'hE6_E6_E6_E6_E6_E6_E6_E6;
    localparam logic [63:0] SEVENS  = 64'hE0_E0_E0_E0_E0_E0_E0_E0;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    logic [31:0] last_digits = 32'h0;
    logic [7:0]  last_dp     = 8'h0;
    logic        last_err    = 1'b0;

    always #5 clk = ~clk;

    seg_scan_decoder_if bus();

    seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Record every accepted frame.
    always @(posedge clk) begin
        if (bus.frame_valid && bus.frame_ready) begin
            hs_cnt      <= hs_cnt + 1;
            last_digits <= bus.frame_digits;
            last_dp     <= bus.frame_dp;
            last_err    <= bus.frame_err;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] sel, input logic [7:0] seg, input int n);
        bus.dig_sel = sel;
        bus.seg_in  = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [63:0] segs, input int lo, input int hi, input int glitch_slot);
        logic [7:0] sel;
        for (int i = lo; i <= hi; i++) begin
            sel = 8'h01 << i;
            if (i == glitch_slot) begin
                put(sel, 8'h6E, 2);
                put(sel, 8'h60, 4);
            end else begin
                put(sel, segs[8*i +: 8], 6);
            end
        end
        put(8'h00, 8'h00, 4);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_digits"}, bus.frame_digits, 32'h0);
        check_eq({tag, "_dp"}, {24'h0, bus.frame_dp}, 32'h0);
        check_eq({tag, "_err"}, {31'h0, bus.frame_err}, 32'h0);
        check_eq({tag, "_valid"}, {31'h0, bus.frame_valid}, 32'h0);
        check_eq({tag, "_overrun"}, {31'h0, bus.overrun}, 32'h0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.seg_in      = 8'h00;
        bus.dig_sel     = 8'h00;
        bus.frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Clean scan
        scan(CLEAN, 0, 7, -1);
        check_eq("clean_frames", hs_cnt, 32'd1);
        check_eq("clean_digits", last_digits, 32'h8210_9ba3);
        check_eq("clean_err", {31'h0, last_err}, 32'h0);
        check_eq("clean_dp", {24'h0, last_dp}, 32'h0);
        check_eq("clean_valid_drop", {31'h0, bus.frame_valid}, 32'h0);

        // Invalid pattern with DP lit in slot 5
        scan(INVAL, 0, 7, -1);
        check_eq("inval_frames", hs_cnt, 32'd2);
        check_eq("inval_digits", last_digits, 32'h82f0_9ba3);
        check_eq("inval_err", {31'h0, last_err}, 32'h1);
        check_eq("inval_dp", {24'h0, last_dp}, 32'h20);

        // Short glitch in slot 5 must not be committed
        scan(CLEAN, 0, 7, 5);
        check_eq("glitch_frames", hs_cnt, 32'd3);
        check_eq("glitch_digits", last_digits, 32'h8210_9ba3);
        check_eq("glitch_err", {31'h0, last_err}, 32'h0);

        // Illegal selects between slots 6 and 7
        scan(COUNT, 0, 6, -1);
        put(8'h00, 8'h66, 10);
        put(8'h03, 8'h66, 10);
        check_eq("illegal_no_frame", hs_cnt, 32'd3);
        check_eq("illegal_valid", {31'h0, bus.frame_valid}, 32'h0);
        scan(COUNT, 7, 7, -1);
        check_eq("illegal_frames", hs_cnt, 32'd4);
        check_eq("illegal_digits", last_digits, 32'h7654_3210);

        // Backpressure and overrun
        bus.frame_ready = 1'b0;
        scan(COUNT, 0, 7, -1);
        check_eq("bp_valid_a", {31'h0, bus.frame_valid}, 32'h1);
        check_eq("bp_digits_a", bus.frame_digits, 32'h7654_3210);
        check_eq("bp_overrun_a", {31'h0, bus.overrun}, 32'h0);
        scan(EIGHTS, 0, 3, -1);
        check_eq("bp_digits_mid", bus.frame_digits, 32'h7654_3210);
        scan(EIGHTS, 4, 7, -1);
        check_eq("bp_valid_b", {31'h0, bus.frame_valid}, 32'h1);
        check_eq("bp_digits_b", bus.frame_digits, 32'h7654_3210);
        check_eq("bp_overrun_b", {31'h0, bus.overrun}, 32'h1);
        check_eq("bp_no_accept", hs_cnt, 32'd4);
        bus.frame_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_valid_drop", {31'h0, bus.frame_valid}, 32'h0);
        check_eq("bp_accept", hs_cnt, 32'd5);
        check_eq("bp_accept_digits", last_digits, 32'h7654_3210);
        scan(NINES, 0, 7, -1);
        check_eq("bp_third_frames", hs_cnt, 32'd6);
        check_eq("bp_third_digits", last_digits, 32'h9999_9999);
        check_eq("bp_overrun_sticky", {31'h0, bus.overrun}, 32'h1);

        // Reset after four committed digits
        scan(SEVENS, 0, 3, -1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("rst_during");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("rst_after");
        scan(CLEAN, 4, 7, -1);
        check_eq("rst_partial_no_frame", hs_cnt, 32'd6);
        scan(CLEAN, 0, 3, -1);
        check_eq("rst_frames", hs_cnt, 32'd7);
        check_eq("rst_digits", last_digits, 32'h8210_9ba3);
        check_eq("rst_overrun", {31'h0, bus.overrun}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Inverse of the digit-to-segment encoder: snoops the multiplexed 8-digit seven-segment bus (segment byte plus one-hot digit select), waits for each digit's pattern to be stable, decodes it back to the 4-bit digit code, and assembles complete 8-digit frames. It sits beside the display driver and gives self-test and readback logic a valid/ready stream of what is actually on the display.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required to commit a digit; legal range 2..255.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `seg_in` input, 8 bits: segment byte; bit7 = A … bit1 = G, bit0 = DP; 1 = segment lit.
- `dig_sel` input, 8 bits: digit enable, active-high; exactly one bit set is a legal scan slot.
- `frame_ready` input, 1 bit: consumer accepts the frame.
- `frame_digits` output, 32 bits: digit i code in [4i+3:4i], where i is the `dig_sel` bit index.
- `frame_dp` output, 8 bits: DP bit per digit.
- `frame_err` output, 1 bit: the frame contains at least one code 4'hf.
- `frame_valid` output, 1 bit: frame outputs hold a frame not yet accepted.
- `overrun` output, 1 bit: sticky; a completed frame was dropped.

## Operation
- **Input stage:** `seg_in` and `dig_sel` are registered once (`seg_q`, `sel_q`). All further logic uses the registered values.
- **Decode** uses `seg_q[7:1]`. The DP bit is captured separately.
  - 0xFC→0, 0x60→1, 0xDA→2, 0xF2→3, 0x66→4, 0xB6→5, 0xBE→6, 0xE0→7, 0xFE→8, 0xE6→9.
  - 0x02→4'ha (minus), 0x00→4'hb (blank).
  - Any other pattern→4'hf (invalid).
  - Full-byte values are given with DP = 0; DP is masked off for the match.
- **Capture FSM**, states TRACK and HELD, with an 8-bit stability counter:
  - TRACK: if `{seg_q, sel_q}` equals the previous registered sample and `sel_q` is one-hot, increment the counter; otherwise load it with 1.
  - When the counter reaches `STABLE_CYCLES`, commit and go to HELD.
  - Commit: write the decoded code and DP into slot index(`sel_q`) and set `seen[index]`.
  - HELD: no further commits. Any change of `{seg_q, sel_q}` loads the counter with 1 and returns to TRACK.
  - `sel_q` zero or multi-hot: the counter loads 0, state goes to TRACK, nothing is committed.
- **Frame assembly:**
  - A commit that makes `seen` all-ones completes a frame. Digit and DP slots keep their values across frames.
  - Completion clears `seen` on the same edge as that commit.
  - The completed frame is offered on the next edge. If the output is free (`!frame_valid`, or `frame_valid && frame_ready` on that edge), load `frame_digits`, `frame_dp` and `frame_err` and set `frame_valid`.
  - If the output is still held, drop the new frame and set `overrun`. Existing outputs are unchanged.
- **Handshake:** `frame_valid` stays high with stable outputs until the edge where `frame_ready` = 1; it then clears unless a new frame loads on that same edge.
- Recommitting a digit before the frame is complete overwrites the slot; `seen` is unaffected.
- **Reset values:**
  - All outputs 0.
  - Digit slots 4'hb, DP slots 0, `seen` 0.
  - Counter 0, state TRACK, input registers 0.
  - Reset mid-frame discards the partial frame.
  - `overrun` clears only on reset.

## Timing
- Let a pair be presented on `seg_in`/`dig_sel` before edge k and held. `seg_q` updates at edge k and the counter reaches `STABLE_CYCLES` at edge k+S-1 (S = `STABLE_CYCLES`).
- The commit is therefore visible after edge k+S-1.
- The completing commit at edge t sets `frame_valid` after edge t+1.
- A pair held for fewer than S input cycles is never committed.
- Throughput: at most one commit per stable run; back-to-back frames are possible when the consumer keeps `frame_ready` high.

## Test plan
- **Clean scan:** scan digits 0..7 showing "3", "-", blank, "9", "0", "1", "2", "8", each slot held 6 cycles, S=4, `frame_ready`=1 → one `frame_valid` pulse; `frame_digits`=32'h8210_9ba3, `frame_err`=0.
- **Glitch rejection:** in a slot held 6 cycles, present 0x6E for 2 cycles then 0x60 for 4 cycles (S=4) → slot decodes 1, no 4'hf, no commit of 0x6E.
- **Invalid pattern:** slot 5 holds 0x81 for 6 cycles in an otherwise clean scan → nibble 5 = 4'hf, `frame_err`=1.
- **Backpressure:** `frame_ready`=0, run two full scans → first frame is held stable throughout, `overrun`=1 after the second completes; pulse `frame_ready` → `frame_valid` drops next edge; a third scan loads normally.
- **Illegal select:** `dig_sel`=8'h00 or 8'h03 held 10 cycles → no commit, `seen` unchanged.
- **Reset mid-frame:** assert `rst` after 4 committed digits, then run a full scan → exactly one frame, containing only post-reset digits; all outputs were 0 during and after the reset.
